// File: rtl/decode_scan.sv
// decode_scan: registered SEL_W-to-2**SEL_W one-hot decoder for display and
// row-select pins.
//   direct mode (mode=0): decodes a select value taken by a valid/ready handshake.
//   scan mode   (mode=1): a dwell timer steps y through channels 0..scan_last.
// Optional feature macro: SCAN_BLANK_EN. When it is defined, BLANK_CYC all-zero
// cycles are inserted between scan channels to stop ghosting on multiplexed
// displays. Without the macro the BLANK state does not exist and BLANK_CYC has
// no effect.
module decode_scan #(
   parameter  int SEL_W     = 3,
   parameter  int DWELL     = 1000,
   parameter  int BLANK_CYC = 2,
   localparam int OUT_W     = 2 ** SEL_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             mode,
   input  logic [SEL_W-1:0] sel,
   input  logic             sel_valid,
   output logic             sel_ready,
   input  logic [SEL_W-1:0] scan_last,
   output logic [OUT_W-1:0] y,
   output logic [SEL_W-1:0] idx,
   output logic             wrap
);

   // Counter widths. A one-cycle dwell or blank still gets a 1-bit counter so
   // that the compare logic stays uniform.
   localparam int                 DWELL_W   = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(DWELL - 1);

`ifdef SCAN_BLANK_EN
   localparam int                 BLANK_W   = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
   localparam logic [BLANK_W-1:0] BLANK_MAX = BLANK_W'(BLANK_CYC - 1);
`endif

   // Reject parameter values that would give a zero-length dwell or blank.
   if (DWELL < 1) begin : g_bad_dwell
      $error("decode_scan: DWELL must be >= 1");
   end
   if (BLANK_CYC < 1) begin : g_bad_blank
      $error("decode_scan: BLANK_CYC must be >= 1");
   end

`ifdef SCAN_BLANK_EN
   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_DIR   = 2'd1,
      ST_SCAN  = 2'd2,
      ST_BLANK = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_DIR  = 2'd1,
      ST_SCAN = 2'd2
   } state_t;
`endif

   state_t             state, state_nxt;
   logic [OUT_W-1:0]   y_nxt;
   logic [SEL_W-1:0]   idx_nxt;
   logic               wrap_nxt;
   logic [DWELL_W-1:0] dwell_cnt, dwell_nxt;
`ifdef SCAN_BLANK_EN
   logic [BLANK_W-1:0] blank_cnt, blank_nxt;
`endif

   logic               handshake;
   logic               scan_wrap;
   logic [SEL_W-1:0]   idx_adv;

   // Returns a vector with only bit i set.
   function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] i);
      logic [OUT_W-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // Ready is purely combinational, so a select offered while the block is
   // still OFF is taken on the same edge that enters DIR.
   assign sel_ready = en & ~mode;
   assign handshake = sel_valid & sel_ready;

   // The channel that follows idx. The >= compare makes a scan_last lowered
   // below the current channel wrap to 0 at the next advance.
   assign scan_wrap = (idx >= scan_last);
   assign idx_adv   = scan_wrap ? '0 : idx + 1'b1;

   // Next-state logic and next values for the registered outputs and counters.
   always_comb begin
      // NOTE: every variable written in this block gets a default first. A path
      // that missed one would infer a latch.
      state_nxt = state;
      y_nxt     = y;
      idx_nxt   = idx;
      wrap_nxt  = 1'b0;
      dwell_nxt = dwell_cnt;
`ifdef SCAN_BLANK_EN
      blank_nxt = blank_cnt;
`endif

      if (!en) begin
         // Disabled from any state: blank the pins and clear the timers.
         // idx is kept so that software can still read where the scan stopped.
         state_nxt = ST_OFF;
         y_nxt     = '0;
         dwell_nxt = '0;
`ifdef SCAN_BLANK_EN
         blank_nxt = '0;
`endif
      end else if (!mode) begin
         // Direct mode. Coming in from any other state blanks y until the
         // first select is accepted.
         state_nxt = ST_DIR;
         if (state != ST_DIR) begin
            y_nxt     = '0;
            dwell_nxt = '0;
`ifdef SCAN_BLANK_EN
            blank_nxt = '0;
`endif
         end
         if (handshake) begin
            y_nxt   = onehot(sel);
            idx_nxt = sel;
         end
      end else if (state == ST_OFF || state == ST_DIR) begin
         // Scan entry: channel 0 is driven on this same edge, with no wrap pulse.
         state_nxt = ST_SCAN;
         y_nxt     = onehot('0);
         idx_nxt   = '0;
         dwell_nxt = '0;
`ifdef SCAN_BLANK_EN
         blank_nxt = '0;
`endif
      end else begin
         case (state)
            ST_SCAN: begin
               if (dwell_cnt == DWELL_MAX) begin
                  // Dwell finished: move to the next channel. scan_last is
                  // sampled only here.
                  idx_nxt   = idx_adv;
                  wrap_nxt  = scan_wrap;
                  dwell_nxt = '0;
`ifdef SCAN_BLANK_EN
                  // Drive nothing for a few cycles before the new channel.
                  y_nxt     = '0;
                  blank_nxt = '0;
                  state_nxt = ST_BLANK;
`else
                  y_nxt     = onehot(idx_adv);
`endif
               end else begin
                  dwell_nxt = dwell_cnt + 1'b1;
               end
            end
`ifdef SCAN_BLANK_EN
            ST_BLANK: begin
               if (blank_cnt == BLANK_MAX) begin
                  // Blanking done: drive the channel that was chosen at dwell end.
                  y_nxt     = onehot(idx);
                  dwell_nxt = '0;
                  blank_nxt = '0;
                  state_nxt = ST_SCAN;
               end else begin
                  blank_nxt = blank_cnt + 1'b1;
               end
            end
`endif
            default: begin
               // Unreachable encoding: fall back to a safe, blank state.
               state_nxt = ST_OFF;
               y_nxt     = '0;
               dwell_nxt = '0;
            end
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_OFF;
      end else begin
         // NOTE: sequential state uses non-blocking assignments, so every
         // register samples the values that were present before the edge.
         state <= state_nxt;
      end
   end

   // Output and timer registers. The asynchronous reset clears them immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y         <= '0;
         idx       <= '0;
         wrap      <= 1'b0;
         dwell_cnt <= '0;
`ifdef SCAN_BLANK_EN
         blank_cnt <= '0;
`endif
      end else begin
         y         <= y_nxt;
         idx       <= idx_nxt;
         wrap      <= wrap_nxt;
         dwell_cnt <= dwell_nxt;
`ifdef SCAN_BLANK_EN
         blank_cnt <= blank_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_decode_scan.sv
// tb_decode_scan: directed, scoreboard-checked bench for decode_scan with
// SEL_W=3, DWELL=4 and BLANK_CYC=2. Define SCAN_BLANK_EN for both the bench and
// the RTL to cover the blanking variant.
module tb_decode_scan;

   localparam int SEL_W     = 3;
   localparam int OUT_W     = 8;
   localparam int DWELL     = 4;
   localparam int BLANK_CYC = 2;

   logic             clk       = 1'b0;
   logic             rst_n     = 1'b1;
   logic             en        = 1'b0;
   logic             mode      = 1'b0;
   logic [SEL_W-1:0] sel       = '0;
   logic             sel_valid = 1'b0;
   logic             sel_ready;
   logic [SEL_W-1:0] scan_last = '0;
   logic [OUT_W-1:0] y;
   logic [SEL_W-1:0] idx;
   logic             wrap;

   decode_scan #(
      .SEL_W    (SEL_W),
      .DWELL    (DWELL),
      .BLANK_CYC(BLANK_CYC)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .mode     (mode),
      .sel      (sel),
      .sel_valid(sel_valid),
      .sel_ready(sel_ready),
      .scan_last(scan_last),
      .y        (y),
      .idx      (idx),
      .wrap     (wrap)
   );

   always #5 clk = ~clk;

   typedef struct {
      string            tag;
      logic [OUT_W-1:0] y;
      logic [SEL_W-1:0] idx;
      logic             wrap;
   } exp_t;

   exp_t sb[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   // Single comparison point. Values are packed into 32 bits for reporting.
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Pushes the expected {y, idx, wrap} for the coming edge, then pops it and
   // compares it with the DUT #1 after that edge.
   task automatic step(input string tag, input logic [OUT_W-1:0] ey,
                       input logic [SEL_W-1:0] eidx, input logic ew);
      exp_t e;
      e.tag  = tag;
      e.y    = ey;
      e.idx  = eidx;
      e.wrap = ew;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check(e.tag, {20'd0, y, idx, wrap}, {20'd0, e.y, e.idx, e.wrap});
   endtask

   function automatic logic [OUT_W-1:0] bit_of(input int ch);
      logic [OUT_W-1:0] one;
      one = 1;
      return one << ch;
   endfunction

   // Expects n cycles on channel ch, none of them an advance.
   task automatic hold(input int ch, input int n);
      for (int i = 0; i < n; i++)
         step($sformatf("hold_ch%0d", ch), bit_of(ch), SEL_W'(ch), 1'b0);
   endtask

   // Expects an advance to channel ch (w = wrap expected), followed by n cycles
   // of that channel. With blanking, the advance shows up as blank cycles that
   // already carry the new idx.
   task automatic chan(input int ch, input int n, input logic w);
`ifdef SCAN_BLANK_EN
      for (int b = 0; b < BLANK_CYC; b++)
         step($sformatf("blank_to_ch%0d", ch), '0, SEL_W'(ch), w && (b == 0));
      for (int i = 0; i < n; i++)
         step($sformatf("chan_ch%0d", ch), bit_of(ch), SEL_W'(ch), 1'b0);
`else
      for (int i = 0; i < n; i++)
         step($sformatf("chan_ch%0d", ch), bit_of(ch), SEL_W'(ch), w && (i == 0));
`endif
   endtask

   initial begin
      // Asynchronous reset, with no clock edge involved.
      #2 rst_n = 1'b0;
      #1;
      check("rst_y_idx_wrap", {20'd0, y, idx, wrap}, 32'd0);
      check("rst_ready", {31'd0, sel_ready}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      step("off_idle", 8'h00, 3'd0, 1'b0);

      // Direct mode: accept sel=5, then hold it.
      en = 1'b1;
      mode = 1'b0;
      #0 check("ready_direct", {31'd0, sel_ready}, 32'd1);
      sel = 3'd5;
      sel_valid = 1'b1;
      step("dir_sel5", 8'h20, 3'd5, 1'b0);
      sel_valid = 1'b0;
      sel = 3'd2;
      step("dir_hold5_a", 8'h20, 3'd5, 1'b0);
      step("dir_hold5_b", 8'h20, 3'd5, 1'b0);
      for (int s = 0; s < 8; s++) begin
         sel = SEL_W'(s);
         sel_valid = 1'b1;
         step($sformatf("dir_sweep%0d", s), bit_of(s), SEL_W'(s), 1'b0);
      end
      sel_valid = 1'b0;
      step("dir_hold7", 8'h80, 3'd7, 1'b0);

      // Scan mode with scan_last=3. sel_valid is left high and must be ignored.
      sel = 3'd6;
      sel_valid = 1'b1;
      mode = 1'b1;
      scan_last = 3'd3;
      #0 check("ready_scan", {31'd0, sel_ready}, 32'd0);
      hold(0, 4);
      chan(1, 4, 1'b0);
      chan(2, 4, 1'b0);
      chan(3, 4, 1'b0);
      chan(0, 4, 1'b1);
      chan(1, 4, 1'b0);
      chan(2, 4, 1'b0);
      chan(3, 4, 1'b0);
      chan(0, 1, 1'b1);
      sel_valid = 1'b0;

      // Raise scan_last to 7, then lower it to 2 while idx is 5.
      scan_last = 3'd7;
      hold(0, 3);
      chan(1, 4, 1'b0);
      chan(2, 4, 1'b0);
      chan(3, 4, 1'b0);
      chan(4, 4, 1'b0);
      chan(5, 1, 1'b0);
      scan_last = 3'd2;
      hold(5, 3);
      chan(0, 4, 1'b1);
      chan(1, 4, 1'b0);
      chan(2, 4, 1'b0);
      chan(0, 1, 1'b1);

      // en low in the middle of a scan, then a restart and a switch to direct mode.
      scan_last = 3'd3;
      hold(0, 3);
      chan(1, 2, 1'b0);
      en = 1'b0;
      #0 check("ready_off", {31'd0, sel_ready}, 32'd0);
      step("off_idx_held_a", 8'h00, 3'd1, 1'b0);
      step("off_idx_held_b", 8'h00, 3'd1, 1'b0);
      en = 1'b1;
      step("scan_restart", 8'h01, 3'd0, 1'b0);
      hold(0, 3);
      chan(1, 1, 1'b0);
      mode = 1'b0;
      #0 check("ready_back_direct", {31'd0, sel_ready}, 32'd1);
      step("dir_entry_a", 8'h00, 3'd1, 1'b0);
      step("dir_entry_b", 8'h00, 3'd1, 1'b0);
      sel = 3'd3;
      sel_valid = 1'b1;
      step("dir_sel3", 8'h08, 3'd3, 1'b0);
      sel_valid = 1'b0;

      // Asynchronous reset between clock edges, in the middle of a scan.
      mode = 1'b1;
      step("scan_entry_from_dir", 8'h01, 3'd0, 1'b0);
      hold(0, 3);
      chan(1, 2, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_mid_scan", {20'd0, y, idx, wrap}, 32'd0);
      #2 rst_n = 1'b1;
      step("post_rst_scan_entry", 8'h01, 3'd0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
